// File: rtl/mig_pkg.sv
// Shared MIG definitions: user-port instruction codes and the
// per-burst routing tag used by the read arbiter.
package mig_pkg;

  localparam logic [2:0] CMD_WRITE           = 3'd0;
  localparam logic [2:0] CMD_READ            = 3'd1;
  localparam logic [2:0] CMD_WRITE_PRECHARGE = 3'd2;
  localparam logic [2:0] CMD_READ_PRECHARGE  = 3'd3;
  localparam logic [2:0] CMD_REFRESH         = 3'd4;
  localparam logic [2:0] CMD_IDLE            = 3'd5;

  typedef struct packed {
    logic       client;
    logic [5:0] bl;
  } tag_t;

endpackage

// File: rtl/tag_fifo.sv
// In-order burst tag FIFO for the MIG read arbiter.
// Synchronous clear; push and pop may occur in the same cycle.
module tag_fifo #(
  parameter int DEPTH_LOG2 = 2,
  parameter int WIDTH      = 7
) (
  input  logic             rclk,
  input  logic             rresetb,
  input  logic             i_clear,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_din,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_dout,
  output logic             o_full,
  output logic             o_empty
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [WIDTH-1:0]      r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wp;
  logic [DEPTH_LOG2-1:0] r_rp;
  logic [DEPTH_LOG2:0]   r_cnt;
  logic                  w_push;
  logic                  w_pop;

  assign o_full  = (r_cnt == (DEPTH_LOG2+1)'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_dout  = r_mem[r_rp];
  assign w_push  = i_push && !o_full;
  assign w_pop   = i_pop && !o_empty;

  always_ff @(posedge rclk) begin
    if (w_push && !i_clear)
      r_mem[r_wp] <= i_din;
  end

  always_ff @(posedge rclk or negedge rresetb) begin
    if (!rresetb) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else if (i_clear) begin
      r_wp  <= '0;
      r_rp  <= '0;
      r_cnt <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop)  r_rp <= r_rp + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 1'b1;
        2'b01:   r_cnt <= r_cnt - 1'b1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

endmodule

// File: rtl/mig_rd_arbiter.sv
// Two-client burst read arbiter for one MIG user read port.
// MIG_RD_ARB_FIXED_PRIO_EN: client 0 always wins contention.
module mig_rd_arbiter
  import mig_pkg::*;
#(
  parameter int ADDR_WIDTH     = 30,
  parameter int TAG_DEPTH_LOG2 = 2,
  parameter int RD_FIFO_WORDS  = 64
) (
  input  logic                  rclk,
  input  logic                  rresetb,
  input  logic                  enable,
  input  logic                  c0_req,
  input  logic                  c1_req,
  input  logic [5:0]            c0_bl,
  input  logic [5:0]            c1_bl,
  input  logic [ADDR_WIDTH-1:0] c0_addr,
  input  logic [ADDR_WIDTH-1:0] c1_addr,
  output logic                  c0_ack,
  output logic                  c1_ack,
  output logic                  c0_rd_valid,
  output logic                  c1_rd_valid,
  output logic [31:0]           c0_rd_data,
  output logic [31:0]           c1_rd_data,
  output logic                  pR_cmd_en,
  output logic [2:0]            pR_cmd_instr,
  output logic [5:0]            pR_cmd_bl,
  output logic [ADDR_WIDTH-1:0] pR_cmd_byte_addr,
  input  logic                  pR_cmd_full,
  output logic                  pR_rd_en,
  input  logic [31:0]           pR_rd_data,
  input  logic                  pR_rd_empty,
  output logic                  busy
);

  localparam logic [7:0] CREDITS = 8'(RD_FIFO_WORDS);

  logic                  r_cmd_en;
  logic                  r_ack0;
  logic                  r_ack1;
  logic                  r_v0;
  logic                  r_v1;
  logic [31:0]           r_d0;
  logic [31:0]           r_d1;
  logic [5:0]            r_bl;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic [5:0]            r_wcnt;
  logic [6:0]            r_out;
`ifndef MIG_RD_ARB_FIXED_PRIO_EN
  logic                  r_last;
`endif

  logic                  w_flush;
  logic                  w_win;
  logic                  w_grant;
  logic                  w_fit;
  logic                  w_rd_en;
  logic                  w_word;
  logic                  w_pop;
  logic                  w_clear;
  logic                  w_tfull;
  logic                  w_tempty;
  logic [5:0]            w_bl;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [6:0]            w_inc;
  logic [6:0]            w_dec;
  tag_t                  w_head;
  tag_t                  w_ptag;

  assign w_flush = !enable;

  // A blocked winner stalls the loser too; no bypass.
  always_comb begin
    w_win = c1_req;
    if (c0_req && c1_req) begin
`ifdef MIG_RD_ARB_FIXED_PRIO_EN
      w_win = 1'b0;
`else
      w_win = !r_last;
`endif
    end
    w_bl    = w_win ? c1_bl : c0_bl;
    w_addr  = w_win ? c1_addr : c0_addr;
    w_fit   = ({1'b0, r_out} + {2'b0, w_bl} + 8'd1) <= CREDITS;
    w_grant = (c0_req || c1_req) && enable && !pR_cmd_full
              && !r_cmd_en && !w_tfull && w_fit;
    w_inc   = w_grant ? ({1'b0, w_bl} + 7'd1) : 7'd0;
  end

  assign w_rd_en = !pR_rd_empty && (!w_tempty || w_flush);
  assign w_word  = w_rd_en && !w_flush;
  assign w_pop   = w_word && (r_wcnt == w_head.bl);
  assign w_clear = w_flush && pR_rd_empty;
  assign w_dec   = {6'd0, w_word};
  assign w_ptag  = '{client: w_win, bl: w_bl};

  tag_fifo #(
    .DEPTH_LOG2 (TAG_DEPTH_LOG2),
    .WIDTH      (7)
  ) u_tags (
    .rclk    (rclk),
    .rresetb (rresetb),
    .i_clear (w_clear),
    .i_push  (w_grant),
    .i_din   (w_ptag),
    .i_pop   (w_pop),
    .o_dout  (w_head),
    .o_full  (w_tfull),
    .o_empty (w_tempty)
  );

  always_ff @(posedge rclk or negedge rresetb) begin
    if (!rresetb) begin
      r_cmd_en <= 1'b0;
      r_ack0   <= 1'b0;
      r_ack1   <= 1'b0;
      r_v0     <= 1'b0;
      r_v1     <= 1'b0;
      r_d0     <= '0;
      r_d1     <= '0;
      r_bl     <= '0;
      r_addr   <= '0;
      r_wcnt   <= '0;
      r_out    <= '0;
`ifndef MIG_RD_ARB_FIXED_PRIO_EN
      r_last   <= 1'b1;
`endif
    end else begin
      r_cmd_en <= w_grant;
      r_ack0   <= w_grant && !w_win;
      r_ack1   <= w_grant && w_win;
      if (w_grant) begin
        r_bl   <= w_bl;
        r_addr <= {w_addr[ADDR_WIDTH-1:2], 2'b00};
      end
      r_v0 <= w_word && !w_head.client;
      r_v1 <= w_word && w_head.client;
      if (w_word && !w_head.client) r_d0 <= pR_rd_data;
      if (w_word && w_head.client)  r_d1 <= pR_rd_data;
      if (w_clear) begin
        r_wcnt <= '0;
        r_out  <= '0;
      end else begin
        if (w_word) r_wcnt <= w_pop ? 6'd0 : r_wcnt + 6'd1;
        r_out <= r_out + w_inc - w_dec;
      end
`ifndef MIG_RD_ARB_FIXED_PRIO_EN
      if (w_flush)      r_last <= 1'b1;
      else if (w_grant) r_last <= w_win;
`endif
    end
  end

  assign c0_ack           = r_ack0;
  assign c1_ack           = r_ack1;
  assign c0_rd_valid      = r_v0;
  assign c1_rd_valid      = r_v1;
  assign c0_rd_data       = r_d0;
  assign c1_rd_data       = r_d1;
  assign pR_cmd_en        = r_cmd_en;
  assign pR_cmd_instr     = CMD_READ;
  assign pR_cmd_bl        = r_bl;
  assign pR_cmd_byte_addr = r_addr;
  assign pR_rd_en         = w_rd_en;
  assign busy             = (r_out != 7'd0) || r_cmd_en;

endmodule

// File: tb/tb_mig_rd_arbiter.sv
// Directed/random bench for mig_rd_arbiter with a queue-based
// MIG read-FIFO model and per-client expected-word scoreboards.
module tb_mig_rd_arbiter;

  logic        rclk = 1'b0;
  logic        rresetb = 1'b0;
  logic        enable = 1'b0;
  logic        c0_req = 1'b0;
  logic        c1_req = 1'b0;
  logic [5:0]  c0_bl = '0;
  logic [5:0]  c1_bl = '0;
  logic [29:0] c0_addr = '0;
  logic [29:0] c1_addr = '0;
  logic        c0_ack, c1_ack, c0_rd_valid, c1_rd_valid;
  logic [31:0] c0_rd_data, c1_rd_data;
  logic        pR_cmd_en;
  logic [2:0]  pR_cmd_instr;
  logic [5:0]  pR_cmd_bl;
  logic [29:0] pR_cmd_byte_addr;
  logic        pR_cmd_full = 1'b0;
  logic        pR_rd_en;
  logic [31:0] pR_rd_data;
  logic        pR_rd_empty;
  logic        busy;

  int          total = 0;
  int          bad = 0;
  logic [31:0] mq[$];
  logic [31:0] exp0[$];
  logic [31:0] exp1[$];
  int          mq_n = 0;
  logic [31:0] mq_head = '0;
  int          allow = -1;
  bit          in_flush = 1'b0;
  int          n_v0 = 0;
  int          n_v1 = 0;

  assign pR_rd_empty = (mq_n == 0) || (allow == 0);
  assign pR_rd_data  = mq_head;

  always #5 rclk = ~rclk;

  mig_rd_arbiter dut (
    .rclk(rclk), .rresetb(rresetb), .enable(enable),
    .c0_req(c0_req), .c1_req(c1_req),
    .c0_bl(c0_bl), .c1_bl(c1_bl),
    .c0_addr(c0_addr), .c1_addr(c1_addr),
    .c0_ack(c0_ack), .c1_ack(c1_ack),
    .c0_rd_valid(c0_rd_valid), .c1_rd_valid(c1_rd_valid),
    .c0_rd_data(c0_rd_data), .c1_rd_data(c1_rd_data),
    .pR_cmd_en(pR_cmd_en), .pR_cmd_instr(pR_cmd_instr),
    .pR_cmd_bl(pR_cmd_bl), .pR_cmd_byte_addr(pR_cmd_byte_addr),
    .pR_cmd_full(pR_cmd_full), .pR_rd_en(pR_rd_en),
    .pR_rd_data(pR_rd_data), .pR_rd_empty(pR_rd_empty),
    .busy(busy)
  );

  task automatic chk(input string tag, input logic [63:0] obs,
                     input logic [63:0] expv);
    total++;
    assert (obs === expv) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, expv);
    end
  endtask

  // Monitor, scoreboard and MIG read-FIFO model
  bit          prev_cmd = 1'b0;
  bit          s_en, s_cmd, s_who;
  logic [5:0]  s_bl;
  logic [31:0] w;
  always begin
    @(negedge rclk);
    if (rresetb) begin
      if (pR_cmd_en || c0_ack || c1_ack)
        chk("ack_onehot", 64'(c0_ack ^ c1_ack), 64'(pR_cmd_en));
      if (pR_cmd_en) begin
        chk("cmd_gap", 64'(prev_cmd), 64'd0);
        chk("cmd_instr", 64'(pR_cmd_instr), 64'd1);
        chk("cmd_bl", 64'(pR_cmd_bl), 64'(c1_ack ? c1_bl : c0_bl));
        chk("cmd_addr", 64'(pR_cmd_byte_addr),
            64'((c1_ack ? c1_addr : c0_addr) & ~30'h3));
      end
      if (in_flush) begin
        chk("flush_quiet",
            64'({c0_rd_valid, c1_rd_valid, c0_ack, c1_ack, pR_cmd_en}),
            64'd0);
      end else begin
        if (c0_rd_valid || c1_rd_valid)
          chk("both_valid", 64'(c0_rd_valid && c1_rd_valid), 64'd0);
        if (c0_rd_valid) begin
          n_v0++;
          chk("c0_extra", 64'(exp0.size() != 0), 64'd1);
          if (exp0.size() != 0)
            chk("c0_data", 64'(c0_rd_data), 64'(exp0.pop_front()));
        end
        if (c1_rd_valid) begin
          n_v1++;
          chk("c1_extra", 64'(exp1.size() != 0), 64'd1);
          if (exp1.size() != 0)
            chk("c1_data", 64'(c1_rd_data), 64'(exp1.pop_front()));
        end
      end
    end
    s_en     = pR_rd_en;
    s_cmd    = pR_cmd_en && rresetb;
    s_who    = c1_ack;
    s_bl     = pR_cmd_bl;
    prev_cmd = pR_cmd_en;
    @(posedge rclk);
    #1;
    if (s_en) begin
      chk("rd_en_empty", 64'(mq.size() != 0), 64'd1);
      if (mq.size() != 0) void'(mq.pop_front());
      if (allow > 0) allow--;
    end
    if (s_cmd) begin
      for (int i = 0; i <= int'(s_bl); i++) begin
        w = $urandom;
        mq.push_back(w);
        if (s_who) exp1.push_back(w);
        else exp0.push_back(w);
      end
    end
    mq_n    = mq.size();
    mq_head = (mq_n != 0) ? mq[0] : 32'd0;
  end

  task automatic step();
    @(posedge rclk);
    #1;
  endtask

  task automatic wait_grant(input int budget, output bit got,
                            output int who, output int lat);
    got = 1'b0;
    who = 0;
    lat = 0;
    for (int i = 1; i <= budget; i++) begin
      @(negedge rclk);
      if (pR_cmd_en) begin
        got = 1'b1;
        who = c1_ack ? 1 : 0;
        lat = i;
        break;
      end
    end
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      @(negedge rclk);
      if (!busy && mq_n == 0 && exp0.size() == 0 && exp1.size() == 0) begin
        ok = 1'b1;
        break;
      end
    end
    chk(tag, 64'(ok), 64'd1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

  bit got;
  int who, lat, ew;
  initial begin
    #3;
    chk("rst_ctl",
        64'({pR_cmd_en, pR_cmd_bl, pR_cmd_byte_addr, pR_rd_en,
             c0_ack, c1_ack, c0_rd_valid, c1_rd_valid, busy}), 64'd0);
    chk("rst_data", 64'({c0_rd_data, c1_rd_data}), 64'd0);
    chk("rst_instr", 64'(pR_cmd_instr), 64'd1);
    step();
    rresetb = 1'b1;
    enable  = 1'b1;
    step();

    // single c0 burst, unaligned address
    n_v0 = 0; n_v1 = 0;
    c0_bl = 6'd15; c0_addr = 30'h1003; c0_req = 1'b1;
    wait_grant(4, got, who, lat);
    chk("t1_got", 64'(got), 64'd1);
    chk("t1_who", 64'(who), 64'd0);
    chk("t1_lat", 64'(lat), 64'd2);
    chk("t1_addr", 64'(pR_cmd_byte_addr), 64'h1000);
    step();
    c0_req = 1'b0;
    wait_idle("t1_idle");
    chk("t1_c0_words", 64'(n_v0), 64'd16);
    chk("t1_c1_words", 64'(n_v1), 64'd0);

    // short flush resets the round-robin pointer
    enable = 1'b0; in_flush = 1'b1;
    repeat (3) step();
    enable = 1'b1; in_flush = 1'b0;

    // both clients contend continuously
    c0_bl = 6'd15; c1_bl = 6'd15;
    c0_addr = $urandom; c1_addr = $urandom;
    c0_req = 1'b1; c1_req = 1'b1;
    for (int k = 0; k < 6; k++) begin
      wait_grant(60, got, who, lat);
      chk("t2_got", 64'(got), 64'd1);
`ifdef MIG_RD_ARB_FIXED_PRIO_EN
      ew = 0;
`else
      ew = k % 2;
`endif
      chk("t2_order", 64'(who), 64'(ew));
      step();
      if (who == 1) c1_addr = $urandom;
      else c0_addr = $urandom;
    end
    c0_req = 1'b0; c1_req = 1'b0;
    wait_idle("t2_idle");

    // credit limit: four bursts fill 64 words, fifth stalls
    step();
    allow = 0;
    c0_bl = 6'd15; c0_addr = $urandom; c0_req = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant(6, got, who, lat);
      chk("t3_fill", 64'(got), 64'd1);
      step();
      c0_addr = $urandom;
    end
    wait_grant(12, got, who, lat);
    chk("t3_stall", 64'(got), 64'd0);
    step();
    allow = 16;
    got = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(negedge rclk);
      if (allow == 0) begin got = 1'b1; break; end
    end
    chk("t3_drain", 64'(got), 64'd1);
    wait_grant(3, got, who, lat);
    chk("t3_regrant", 64'(got), 64'd1);
    step();
    c0_req = 1'b0;
    allow = -1;
    wait_idle("t3_idle");

    // c0 bl=0 followed by c1 bl=3: no gap between bursts
    step();
    allow = 0;
    c0_bl = 6'd0; c0_addr = $urandom; c0_req = 1'b1;
    wait_grant(4, got, who, lat);
    chk("t4_g0", 64'(who), 64'd0);
    step();
    c0_req = 1'b0;
    c1_bl = 6'd3; c1_addr = $urandom; c1_req = 1'b1;
    wait_grant(4, got, who, lat);
    chk("t4_g1", 64'(who), 64'd1);
    step();
    c1_req = 1'b0;
    allow = -1;
    got = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge rclk);
      if (c0_rd_valid || c1_rd_valid) begin got = 1'b1; break; end
    end
    chk("t4_first", 64'(got), 64'd1);
    for (int k = 0; k < 5; k++) begin
      if (k > 0) @(negedge rclk);
      chk("t4_route", 64'({c0_rd_valid, c1_rd_valid}),
          (k == 0) ? 64'd2 : 64'd1);
    end
    wait_idle("t4_idle");

    // command port full for 10 cycles
    step();
    pR_cmd_full = 1'b1;
    c0_bl = 6'($urandom_range(0, 63)); c0_addr = $urandom; c0_req = 1'b1;
    wait_grant(10, got, who, lat);
    chk("t5_blocked", 64'(got), 64'd0);
    step();
    pR_cmd_full = 1'b0;
    wait_grant(4, got, who, lat);
    chk("t5_got", 64'(got), 64'd1);
    chk("t5_lat", 64'(lat), 64'd2);
    step();
    c0_req = 1'b0;
    wait_idle("t5_idle");

    // flush with 20 words outstanding
    step();
    allow = 0;
    c0_bl = 6'd15; c0_addr = $urandom; c0_req = 1'b1;
    wait_grant(4, got, who, lat);
    step();
    c0_req = 1'b0;
    c1_bl = 6'd3; c1_addr = $urandom; c1_req = 1'b1;
    wait_grant(4, got, who, lat);
    step();
    enable = 1'b0; in_flush = 1'b1;
    c0_req = 1'b1; c1_req = 1'b1;
    allow = -1;
    repeat (30) step();
    chk("t6_drained", 64'(mq_n), 64'd0);
    chk("t6_busy", 64'(busy), 64'd0);
    exp0.delete();
    exp1.delete();
    enable = 1'b1; in_flush = 1'b0;
    wait_grant(4, got, who, lat);
    chk("t6_got", 64'(got), 64'd1);
    chk("t6_first_c0", 64'(who), 64'd0);
    step();
    c0_req = 1'b0; c1_req = 1'b0;
    wait_idle("t6_idle");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
